// File: rtl/fifo_status_reg.sv
// fifo_status_reg
//  Read-side responder for the I2S FIFO error status register.
//  Captures i2si overrun and i2so underrun event pulses into sticky flags
//  and saturating counters. The write-side decoder clears them with
//  trig_*_clr pulses. They are returned on a one-cycle-latency read bus.
//  Optional feature macro: FIFO_STATUS_IRQ_EN. When it is defined, a
//  registered level interrupt is driven. When it is undefined, irq is tied low.
`timescale 1ns/1ps

module fifo_status_reg #(
  parameter logic [10:0] STATUS_ADDR  = 11'h00c,
  parameter logic [10:0] OVR_CNT_ADDR = 11'h00d,
  parameter logic [10:0] UDR_CNT_ADDR = 11'h00e,
  parameter int          CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i2si_fifo_overrun,
  input  logic        i2so_fifo_underrun,
  input  logic        trig_i2si_fifo_overrun_clr,
  input  logic        trig_i2so_fifo_underrun_clr,
  input  logic [10:0] address,
  input  logic        rd,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        irq
);

  // Read handshake: a cycle with rd=1 is one request, and there is no ready
  // or stall. The next cycle always carries rvalid=1 with rdata. rdata is
  // taken from the register state before that request edge's update.
  // When rd=0, rvalid is 0 on the next cycle and rdata keeps its last value.

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             ovr_flag, udr_flag;
  logic [CNT_W-1:0] ovr_cnt, udr_cnt;
  logic             ovr_flag_nxt, udr_flag_nxt;
  logic [CNT_W-1:0] ovr_cnt_nxt, udr_cnt_nxt;
  logic [7:0]       ovr_cnt_ext, udr_cnt_ext;
  logic [7:0]       rd_mux;

  // Next flag/counter state per channel: an event beats a same-cycle clear,
  // so a colliding pair restarts the count at 1 instead of losing the event.
  always_comb begin
    ovr_flag_nxt = ovr_flag;
    ovr_cnt_nxt  = ovr_cnt;
    if (i2si_fifo_overrun) begin
      ovr_flag_nxt = 1'b1;
      if (trig_i2si_fifo_overrun_clr)
        ovr_cnt_nxt = CNT_W'(1);
      else if (ovr_cnt != CNT_MAX)
        ovr_cnt_nxt = ovr_cnt + 1'b1;
    end else if (trig_i2si_fifo_overrun_clr) begin
      ovr_flag_nxt = 1'b0;
      ovr_cnt_nxt  = '0;
    end

    udr_flag_nxt = udr_flag;
    udr_cnt_nxt  = udr_cnt;
    if (i2so_fifo_underrun) begin
      udr_flag_nxt = 1'b1;
      if (trig_i2so_fifo_underrun_clr)
        udr_cnt_nxt = CNT_W'(1);
      else if (udr_cnt != CNT_MAX)
        udr_cnt_nxt = udr_cnt + 1'b1;
    end else if (trig_i2so_fifo_underrun_clr) begin
      udr_flag_nxt = 1'b0;
      udr_cnt_nxt  = '0;
    end
  end

  // Flag and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_flag <= 1'b0;
      udr_flag <= 1'b0;
      ovr_cnt  <= '0;
      udr_cnt  <= '0;
    end else begin
      ovr_flag <= ovr_flag_nxt;
      udr_flag <= udr_flag_nxt;
      ovr_cnt  <= ovr_cnt_nxt;
      udr_cnt  <= udr_cnt_nxt;
    end
  end

  // Zero-extend the counters to the 8-bit bus. Slice assignment also works
  // when CNT_W is 8.
  always_comb begin
    ovr_cnt_ext              = '0;
    udr_cnt_ext              = '0;
    ovr_cnt_ext[CNT_W-1:0]   = ovr_cnt;
    udr_cnt_ext[CNT_W-1:0]   = udr_cnt;
  end

  // Address decode on the current (pre-update) state. Unmapped addresses read 0.
  always_comb begin
    rd_mux = 8'h00;
    case (address)
      STATUS_ADDR:  rd_mux = {6'b0, udr_flag, ovr_flag};
      OVR_CNT_ADDR: rd_mux = ovr_cnt_ext;
      UDR_CNT_ADDR: rd_mux = udr_cnt_ext;
      default:      rd_mux = 8'h00;
    endcase
  end

  // Read response register: one rvalid per rd cycle, and rdata holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= 8'h00;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd)
        rdata <= rd_mux;
    end
  end

`ifdef FIFO_STATUS_IRQ_EN
  // Level interrupt that tracks the sticky flags on the same edge they update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      irq <= 1'b0;
    else
      irq <= ovr_flag_nxt | udr_flag_nxt;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_status_reg.sv
// tb_fifo_status_reg
//  Directed scenarios plus randomized traffic for fifo_status_reg, checked
//  against an integer-count reference model and an expected-read queue.
`timescale 1ns/1ps

module tb_fifo_status_reg;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        i2si_fifo_overrun, i2so_fifo_underrun;
  logic        trig_i2si_fifo_overrun_clr, trig_i2so_fifo_underrun_clr;
  logic [10:0] address;
  logic        rd;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        irq;

  always #5 clk = ~clk;

  fifo_status_reg #(.CNT_W(CNT_W)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .i2si_fifo_overrun           (i2si_fifo_overrun),
    .i2so_fifo_underrun          (i2so_fifo_underrun),
    .trig_i2si_fifo_overrun_clr  (trig_i2si_fifo_overrun_clr),
    .trig_i2so_fifo_underrun_clr (trig_i2so_fifo_underrun_clr),
    .address                     (address),
    .rd                          (rd),
    .rdata                       (rdata),
    .rvalid                      (rvalid),
    .irq                         (irq)
  );

  // ---------------- reference model ----------------
  int         m_ovr_cnt, m_udr_cnt;
  bit         m_ovr_flag, m_udr_flag;
  logic [7:0] exp_q[$];
  logic [7:0] last_rdata;
  bit         exp_rv;
  int         n_checks = 0;
  int         n_errors = 0;

  function automatic logic [7:0] model_read(input logic [10:0] a);
    case (a)
      11'h00c: return {6'b0, m_udr_flag, m_ovr_flag};
      11'h00d: return 8'(m_ovr_cnt);
      11'h00e: return 8'(m_udr_cnt);
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit model_irq();
`ifdef FIFO_STATUS_IRQ_EN
    return m_ovr_flag | m_udr_flag;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_ovr_cnt = 0; m_udr_cnt = 0;
    m_ovr_flag = 0; m_udr_flag = 0;
    exp_q.delete();
    last_rdata = 8'h00;
    exp_rv = 0;
  endtask

  task automatic model_update(input bit ev_o, ev_u, cl_o, cl_u);
    if (ev_o) begin
      m_ovr_flag = 1;
      m_ovr_cnt  = cl_o ? 1 : ((m_ovr_cnt + 1 > CNT_MAX) ? CNT_MAX : m_ovr_cnt + 1);
    end else if (cl_o) begin
      m_ovr_flag = 0;
      m_ovr_cnt  = 0;
    end
    if (ev_u) begin
      m_udr_flag = 1;
      m_udr_cnt  = cl_u ? 1 : ((m_udr_cnt + 1 > CNT_MAX) ? CNT_MAX : m_udr_cnt + 1);
    end else if (cl_u) begin
      m_udr_flag = 0;
      m_udr_cnt  = 0;
    end
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs at edge+1, advance the model, then check the
  // outputs 1 ns after the next rising edge.
  task automatic step(input bit ev_o, ev_u, cl_o, cl_u, rd_i, input logic [10:0] a);
    logic [7:0] e;
    i2si_fifo_overrun           = ev_o;
    i2so_fifo_underrun          = ev_u;
    trig_i2si_fifo_overrun_clr  = cl_o;
    trig_i2so_fifo_underrun_clr = cl_u;
    rd                          = rd_i;
    address                     = a;
    if (rd_i) exp_q.push_back(model_read(a));
    exp_rv = rd_i;
    model_update(ev_o, ev_u, cl_o, cl_u);
    @(posedge clk);
    #1;
    check("rvalid", rvalid, exp_rv);
    if (exp_rv && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_rdata = e;
      check($sformatf("rdata@%03h", a), rdata, e);
    end else begin
      check("rdata_hold", rdata, last_rdata);
    end
    check("irq", irq, model_irq());
  endtask

  task automatic rd_at(input logic [10:0] a);
    step(0, 0, 0, 0, 1, a);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 11'h000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    i2si_fifo_overrun = 0; i2so_fifo_underrun = 0;
    trig_i2si_fifo_overrun_clr = 0; trig_i2so_fifo_underrun_clr = 0;
    rd = 0; address = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 8'h00);
    check("reset_rvalid", rvalid, 1'b0);
    check("reset_irq", irq, 1'b0);
    rst = 1'b0;

    // Reset read-back
    rd_at(11'h00c); rd_at(11'h00d); rd_at(11'h00e); idle();

    // Capture: 5 overrun pulses
    repeat (5) step(1, 0, 0, 0, 0, 11'h000);
    rd_at(11'h00c); rd_at(11'h00d); rd_at(11'h00e); idle();

    // Saturation: 300 underrun pulses after clearing overrun
    step(0, 0, 1, 0, 0, 11'h000);
    repeat (300) step(0, 1, 0, 0, 0, 11'h000);
    rd_at(11'h00e); rd_at(11'h00c); idle();

    // Clear collision
    step(0, 0, 1, 1, 0, 11'h000);
    repeat (3) step(1, 0, 0, 0, 0, 11'h000);
    rd_at(11'h00d);
    step(1, 0, 1, 0, 0, 11'h000);
    rd_at(11'h00d); rd_at(11'h00c);
    step(0, 0, 1, 0, 0, 11'h000);
    rd_at(11'h00d); idle();

    // Back-to-back reads, including an unmapped address
    step(0, 1, 0, 0, 0, 11'h000);
    step(1, 0, 0, 0, 0, 11'h000);
    rd_at(11'h00c); rd_at(11'h00d); rd_at(11'h7ff); rd_at(11'h00e);
    // Read colliding with an event returns the pre-event value
    step(1, 0, 0, 0, 1, 11'h00d);
    step(0, 1, 0, 0, 1, 11'h00e);
    idle(); idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [10:0] a;
      case ($urandom_range(0, 3))
        0: a = 11'h00c;
        1: a = 11'h00d;
        2: a = 11'h00e;
        default: a = 11'($urandom_range(0, 2047));
      endcase
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, a);
    end

    // Async reset in the middle of a read with flags set
    step(1, 1, 0, 0, 0, 11'h000);
    rd_at(11'h00c);
    check("pre_rst_rvalid", rvalid, 1'b1);
    rd = 1'b1; address = 11'h00c;
    #2;
    rst = 1'b1;
    #1;
    check("async_rvalid", rvalid, 1'b0);
    check("async_rdata", rdata, 8'h00);
    check("async_irq", irq, 1'b0);
    model_reset();
    rd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_at(11'h00c); rd_at(11'h00d); rd_at(11'h00e); idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
